// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - prioritised NUM_CH-channel interrupt controller with I/O-mapped registers
module intr_ctrl #(
    parameter int                 NUM_CH    = 8,
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 16'hFF00,
    parameter logic [DATA_W-1:0]  VEC_BASE  = 16'h0020
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] irq_in,
    output logic              intr,
    input  logic              inta,
    input  logic              rd,
    input  logic              wr,
    input  logic              iom,
    input  logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_SERV} state_t;
    state_t state_q, state_d;

    logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_CH-1:0] pend_q, pend_d, mask_q, mode_q;
    logic [NUM_CH-1:0] eligible, rise, clr;
    logic              rot_q, wr_q, insvc_q, intr_q;
    logic [IDX_W-1:0]  insvc_idx_q, ptr_q, win_idx;
    logic [DATA_W-1:0] vec_q, rd_data, drv_data;
    logic [ADDR_W-1:0] off;
    logic              win_vld, reg_hit, wr_stb, drv_en;
    logic              wr_mask, wr_pend, wr_mode, wr_ctrl, eoi, ack;
    logic              unused_bits;

    assign off      = address_bus - BASE_ADDR;
    assign reg_hit  = iom && (off < ADDR_W'(4));
    assign wr_stb   = wr && !wr_q && reg_hit;
    assign wr_mask  = wr_stb && (off[1:0] == 2'd0);
    assign wr_pend  = wr_stb && (off[1:0] == 2'd1);
    assign wr_mode  = wr_stb && (off[1:0] == 2'd2);
    assign wr_ctrl  = wr_stb && (off[1:0] == 2'd3);
    assign eoi      = wr_ctrl && data_bus[0] && (state_q == S_SERV);
    assign ack      = (state_q == S_REQ) && win_vld && inta;
    assign eligible = pend_q & ~mask_q;
    assign rise     = sync2_q & ~sync3_q;
    assign intr     = intr_q;
    assign unused_bits = ^{data_bus, off};

    // Rotating search begins one past the last serviced channel.
    always_comb begin
        int start;
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        start   = rot_q ? ((int'(ptr_q) + 1) % NUM_CH) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (start + k) % NUM_CH;
            if (!win_vld && eligible[IDX_W'(idx)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    // Edge bits: set beats clear; level bits simply follow the synchronised line.
    always_comb begin
        clr = '0;
        if (wr_pend) clr = clr | data_bus[NUM_CH-1:0];
        if (ack)     clr = clr | (NUM_CH'(1) << win_idx);
        pend_d = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & sync2_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (win_vld) state_d = S_REQ;
            S_REQ: begin
                if (!win_vld)  state_d = S_IDLE;
                else if (inta) state_d = S_ACK;
            end
            S_ACK:  if (!inta) state_d = S_SERV;
            S_SERV: if (eoi)   state_d = S_IDLE;
            default:           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (off[1:0])
            2'd0: rd_data = DATA_W'(mask_q);
            2'd1: rd_data = DATA_W'(pend_q);
            2'd2: rd_data = DATA_W'(mode_q);
            default: begin
                rd_data[1]   = rot_q;
                rd_data[7:4] = 4'(insvc_idx_q);
                rd_data[8]   = insvc_q;
            end
        endcase
    end

    // Gating with reset_n releases the bus asynchronously even if rd/inta stay high.
    always_comb begin
        drv_en   = 1'b0;
        drv_data = rd_data;
        if (reset_n && rd) begin
            if (inta && state_q == S_ACK) begin
                drv_en   = 1'b1;
                drv_data = vec_q;
            end else if (inta && state_q == S_IDLE) begin
                drv_en   = 1'b1;
                drv_data = VEC_BASE + DATA_W'(NUM_CH);
            end else if (!inta && reg_hit) begin
                drv_en   = 1'b1;
            end
        end
    end

    assign data_bus = drv_en ? drv_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            pend_q      <= '0;
            mask_q      <= '1;
            mode_q      <= '0;
            rot_q       <= 1'b0;
            wr_q        <= 1'b0;
            insvc_q     <= 1'b0;
            insvc_idx_q <= '0;
            ptr_q       <= '0;
            vec_q       <= '0;
            intr_q      <= 1'b0;
            state_q     <= S_IDLE;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            wr_q    <= wr;
            pend_q  <= pend_d;
            state_q <= state_d;
            intr_q  <= (state_d == S_REQ);
            if (wr_mask) mask_q <= data_bus[NUM_CH-1:0];
            if (wr_mode) mode_q <= data_bus[NUM_CH-1:0];
            if (wr_ctrl) rot_q  <= data_bus[1];
            if (ack) begin
                vec_q       <= VEC_BASE + DATA_W'(win_idx);
                insvc_idx_q <= win_idx;
                insvc_q     <= 1'b1;
            end
            if (eoi) begin
                insvc_q <= 1'b0;
                ptr_q   <= insvc_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed self-checking bench for intr_ctrl
module tb_intr_ctrl;

    logic        clk;
    logic        reset_n;
    logic [7:0]  irq_in;
    logic        intr;
    logic        inta;
    logic        rd;
    logic        wr;
    logic        iom;
    logic [15:0] address_bus;
    tri   [15:0] data_bus;
    logic [15:0] tb_data;
    logic        tb_drv;
    logic [15:0] v;
    logic        rot_mode;
    int          tests_run;
    int          tests_failed;

    assign data_bus = tb_drv ? tb_data : 16'hzzzz;

    intr_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq_in      (irq_in),
        .intr        (intr),
        .inta        (inta),
        .rd          (rd),
        .wr          (wr),
        .iom         (iom),
        .address_bus (address_bus),
        .data_bus    (data_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        address_bus = addr;
        iom         = 1'b1;
        tb_data     = data;
        tb_drv      = 1'b1;
        wr          = 1'b1;
        @(negedge clk);
        wr     = 1'b0;
        tb_drv = 1'b0;
        iom    = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        address_bus = addr;
        iom         = 1'b1;
        rd          = 1'b1;
        #2;
        data = data_bus;
        rd   = 1'b0;
        iom  = 1'b0;
    endtask

    task automatic wait_intr(input int max_cyc);
        int n;
        n = 0;
        while (intr !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (intr !== 1'b1) check("intr_timeout", {31'b0, intr}, 32'd1);
    endtask

    // Acknowledge the pending request and leave the block in service.
    task automatic do_ack(output logic [15:0] vec);
        wait_intr(20);
        inta = 1'b1;
        @(posedge clk);
        #1;
        check("intr_fall_on_ack", {31'b0, intr}, 32'd0);
        rd = 1'b1;
        #1;
        vec = data_bus;
        @(negedge clk);
        rd   = 1'b0;
        inta = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_eoi();
        io_write(16'hFF03, rot_mode ? 16'h0003 : 16'h0001);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        irq_in = '0; inta = 0; rd = 0; wr = 0; iom = 0;
        address_bus = '0; tb_data = '0; tb_drv = 0; rot_mode = 0;
        reset_n = 1'b0;
        #1;
        check("rst_intr", {31'b0, intr}, 32'd0);
        check("rst_bus_z", {31'b0, data_bus === 16'hzzzz}, 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        io_read(16'hFF00, v); check("rst_mask", {16'b0, v}, 32'h00FF);
        io_read(16'hFF01, v); check("rst_pend", {16'b0, v}, 32'h0000);
        io_read(16'hFF02, v); check("rst_mode", {16'b0, v}, 32'h0000);
        io_read(16'hFF03, v); check("rst_ctrl", {16'b0, v}, 32'h0000);

        // Edge request on channel 0 with latency count
        io_write(16'hFF00, 16'h00FE);
        io_write(16'hFF02, 16'h0001);
        @(negedge clk); irq_in[0] = 1'b1;
        @(negedge clk); irq_in[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("edge_intr_e2", {31'b0, intr}, 32'd0);
        @(negedge clk);
        check("edge_intr_e3", {31'b0, intr}, 32'd1);
        do_ack(v);
        check("edge_vec", {16'b0, v}, 32'h0020);
        io_read(16'hFF01, v); check("edge_pend_clr", {16'b0, v}, 32'h0000);
        io_read(16'hFF03, v); check("edge_insvc", {16'b0, v}, 32'h0100);
        do_eoi();
        io_read(16'hFF03, v); check("edge_eoi_ctrl", {16'b0, v}, 32'h0000);
        check("edge_idle_intr", {31'b0, intr}, 32'd0);

        // Fixed priority with level channels 2 and 5
        io_write(16'hFF02, 16'h0000);
        io_write(16'hFF00, 16'h0000);
        @(negedge clk); irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        do_ack(v); check("fix_vec1", {16'b0, v}, 32'h0022);
        do_eoi();
        @(negedge clk);
        check("fix_b2b_intr", {31'b0, intr}, 32'd1);
        do_ack(v); check("fix_vec2", {16'b0, v}, 32'h0022);
        irq_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        do_eoi();
        do_ack(v); check("fix_vec3", {16'b0, v}, 32'h0025);
        irq_in[5] = 1'b0;
        repeat (4) @(negedge clk);
        do_eoi();
        repeat (2) @(negedge clk);
        check("fix_idle_intr", {31'b0, intr}, 32'd0);

        // Rotating priority from a fresh pointer
        do_reset();
        io_write(16'hFF00, 16'h0000);
        io_write(16'hFF03, 16'h0002);
        rot_mode = 1'b1;
        io_read(16'hFF03, v); check("rot_ctrl", {16'b0, v}, 32'h0002);
        @(negedge clk); irq_in[1] = 1'b1; irq_in[3] = 1'b1; irq_in[6] = 1'b1;
        do_ack(v); check("rot_vec1", {16'b0, v}, 32'h0021);
        do_eoi();
        do_ack(v); check("rot_vec2", {16'b0, v}, 32'h0023);
        do_eoi();
        do_ack(v); check("rot_vec3", {16'b0, v}, 32'h0026);
        do_eoi();
        do_ack(v); check("rot_vec4", {16'b0, v}, 32'h0021);
        irq_in = '0;
        repeat (4) @(negedge clk);
        do_eoi();

        // Masked edge channel 4 and write-1-to-clear
        io_write(16'hFF02, 16'h0010);
        io_write(16'hFF00, 16'h0010);
        @(negedge clk); irq_in[4] = 1'b1;
        @(negedge clk); irq_in[4] = 1'b0;
        repeat (5) @(negedge clk);
        check("mask_intr", {31'b0, intr}, 32'd0);
        io_read(16'hFF01, v); check("mask_pend", {16'b0, v}, 32'h0010);
        io_write(16'hFF01, 16'h0010);
        io_read(16'hFF01, v); check("w1c_pend", {16'b0, v}, 32'h0000);
        @(negedge clk); irq_in[4] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        address_bus = 16'hFF01; iom = 1'b1; tb_data = 16'h0010; tb_drv = 1'b1; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; tb_drv = 1'b0; iom = 1'b0; irq_in[4] = 1'b0;
        io_read(16'hFF01, v); check("set_wins_pend", {16'b0, v}, 32'h0010);

        // Spurious acknowledge while idle, then a MODE read
        @(negedge clk);
        inta = 1'b1; rd = 1'b1;
        #1;
        check("spur_vec", {16'b0, data_bus}, 32'h0028);
        @(negedge clk);
        check("spur_intr", {31'b0, intr}, 32'd0);
        check("spur_vec_hold", {16'b0, data_bus}, 32'h0028);
        inta = 1'b0; rd = 1'b0;
        io_read(16'hFF02, v); check("mode_read", {16'b0, v}, 32'h0010);

        // Reset in the middle of an acknowledge read
        io_write(16'hFF00, 16'h0000);
        wait_intr(20);
        inta = 1'b1;
        @(posedge clk);
        #1 rd = 1'b1;
        #1;
        check("rack_vec", {16'b0, data_bus}, 32'h0024);
        reset_n = 1'b0;
        #1;
        check("rack_bus_z", {31'b0, data_bus === 16'hzzzz}, 32'd1);
        check("rack_intr", {31'b0, intr}, 32'd0);
        @(negedge clk);
        rd = 1'b0; inta = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        io_read(16'hFF00, v); check("rack_mask", {16'b0, v}, 32'h00FF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
